// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - registered round-robin arbiter with grant locking and hold limit
module rr_lock_arbiter #(
  parameter int N       = 4,
  parameter int IW      = 2,
  parameter int MAXHOLD = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  // Counter only needs to reach MAXHOLD-1; with no limit it just saturates.
  localparam int HW = (MAXHOLD < 2) ? 4 : $clog2(MAXHOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = (MAXHOLD == 0) ? '0 : HW'(MAXHOLD - 1);
  localparam logic [HW-1:0] HOLD_MAX  = '1;

  logic [0:0]    state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic          found;
  logic [IW-1:0] win;
  logic          rel;

  // Search starts just after the last owner, so the last owner is tried last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        win   = IW'((int'(ptr) + k) % N);
      end
    end
  end

  always_comb begin
    rel = done | ~req[ptr];
    if (MAXHOLD != 0 && hold_cnt == HOLD_LAST)
      rel = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
      hold_cnt  <= '0;
      ptr       <= IW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= OWNED;
            grant     <= N'(1) << win;
            grant_idx <= win;
            busy      <= 1'b1;
            ptr       <= win;
            hold_cnt  <= '0;
          end
        end
        default: begin
          if (!rel) begin
            if (hold_cnt != HOLD_MAX)
              hold_cnt <= hold_cnt + 1'b1;
          end else if (found) begin
            grant     <= N'(1) << win;
            grant_idx <= win;
            ptr       <= win;
            hold_cnt  <= '0;
          end else begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
          end
        end
      endcase
    end
  end

endmodule
